// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned N                = 8;
    localparam int unsigned IDW              = 3;
    localparam int unsigned CNTW             = 8;
    localparam int unsigned MAX_HOLD_DEFAULT = 15;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
import rr_arbiter8_pkg::*;

module prio_enc8 (
    input  logic [N-1:0]   d,
    input  logic           en,
    output logic [IDW-1:0] a,
    output logic           v
);

    // Descending scan so the lowest set bit is written last.
    always_comb begin
        a = '0;
        v = en && (|d);
        if (en) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (d[i]) a = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
import rr_arbiter8_pkg::*;

module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           owner_release,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    gnt_d;
    logic [IDW-1:0]  gnt_id_d;
    logic            gnt_valid_d;
    logic            timeout_d;

    logic [N-1:0]    req_rot;
    logic [IDW-1:0]  enc_a;
    logic            enc_v;
    logic [IDW-1:0]  winner;
    logic            normal_exit;
    logic            hold_expired;

    // Rotate right by ptr so the search starts at ptr; map the result back.
    assign req_rot = (req >> ptr_q) | (req << (4'd8 - 4'(ptr_q)));
    assign winner  = enc_a + ptr_q;

    prio_enc8 u_enc (
        .d  (req_rot),
        .en (en),
        .a  (enc_a),
        .v  (enc_v)
    );

    assign normal_exit  = owner_release || !req[gnt_id] || !en;
    assign hold_expired = (cnt_q == CNTW'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (enc_v) begin
                    gnt_d       = N'(1) << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (normal_exit || hold_expired) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id + IDW'(1);
                    timeout_d   = hold_expired && !normal_exit;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized checks of rr_arbiter8 against a cycle-level reference model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       owner_release;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner is -1 when nothing is granted.
    int m_ptr   = 0;
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    bit m_tmo   = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req           (req),
        .owner_release (owner_release),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .gnt_valid     (gnt_valid),
        .timeout       (timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit e, input logic [7:0] r, input bit rel, input bit rs);
        bit quit;
        if (!rs) begin
            m_ptr = 0; m_owner = -1; m_held = 0; m_last = 0; m_tmo = 1'b0;
            return;
        end
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            if (e && r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 8;
                    if (r[idx]) begin
                        m_owner = idx;
                        m_last  = idx;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            quit = rel || !r[m_owner] || !e;
            if (quit || m_held == MAX_HOLD) begin
                m_tmo   = !quit;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply inputs from a negedge, advance one edge, then compare at the next negedge.
    task automatic cycle(input bit e, input logic [7:0] r, input bit rel, input bit rs);
        logic [7:0] exp_gnt;
        en = e; req = r; owner_release = rel; rst_n = rs;
        @(posedge clk);
        model_step(e, r, rel, rs);
        @(negedge clk);
        exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("gnt",       gnt,                  exp_gnt);
        check("gnt_id",    {5'b0, gnt_id},       8'(m_last));
        check("gnt_valid", {7'b0, gnt_valid},    {7'b0, (m_owner >= 0)});
        check("timeout",   {7'b0, timeout},      {7'b0, m_tmo});
    endtask

    initial begin
        logic [7:0] rq;
        en = 1'b1; req = 8'hFF; owner_release = 1'b0; rst_n = 1'b0;
        @(negedge clk);

        // Reset with everything requesting, then first grant goes to 0.
        cycle(1, 8'hFF, 0, 0);
        cycle(1, 8'hFF, 0, 0);
        check("reset_valid", {7'b0, gnt_valid}, 8'h00);
        cycle(1, 8'hFF, 0, 1);
        check("first_id", {5'b0, gnt_id}, 8'h00);

        // Fairness under continuous requests.
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 8'hFF, 1, 1);
            check("gap_idle", {7'b0, gnt_valid}, 8'h00);
            cycle(1, 8'hFF, 0, 1);
            check("rr_id", {5'b0, gnt_id}, 8'(i % 8));
        end
        cycle(1, 8'hFF, 1, 1);

        // Enable gating.
        repeat (5) cycle(0, 8'h10, 0, 1);
        check("gated", gnt, 8'h00);
        cycle(1, 8'h10, 0, 1);
        check("en_gnt", gnt, 8'h10);

        // Wrap search from ptr=5.
        cycle(1, 8'h09, 1, 1);
        cycle(1, 8'h09, 0, 1);
        check("wrap_id0", {5'b0, gnt_id}, 8'h00);
        cycle(1, 8'h09, 1, 1);
        cycle(1, 8'h09, 0, 1);
        check("wrap_id3", {5'b0, gnt_id}, 8'h03);

        // Timeout after MAX_HOLD cycles.
        cycle(1, 8'h04, 1, 1);
        cycle(1, 8'h04, 0, 1);
        check("tmo_id", {5'b0, gnt_id}, 8'h02);
        repeat (MAX_HOLD - 1) cycle(1, 8'h04, 0, 1);
        check("tmo_still_held", {7'b0, gnt_valid}, 8'h01);
        cycle(1, 8'h04, 0, 1);
        check("tmo_pulse", {7'b0, timeout}, 8'h01);
        check("tmo_gnt", gnt, 8'h00);
        cycle(1, 8'h04, 0, 1);
        check("tmo_regrant", gnt, 8'h04);
        check("tmo_clear", {7'b0, timeout}, 8'h00);

        // Dropping req mid-grant, then reset mid-grant.
        cycle(1, 8'h04, 1, 1);
        cycle(1, 8'h40, 0, 1);
        check("own6", {5'b0, gnt_id}, 8'h06);
        cycle(1, 8'h00, 0, 1);
        check("drop_tmo", {7'b0, timeout}, 8'h00);
        cycle(1, 8'h81, 0, 1);
        check("ptr7", {5'b0, gnt_id}, 8'h07);
        cycle(1, 8'h81, 0, 0);
        check("rst_mid", gnt, 8'h00);
        cycle(1, 8'hFF, 0, 1);
        check("rst_ptr0", {5'b0, gnt_id}, 8'h00);

        // Randomized traffic.
        rq = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 8 == 0) rq = 8'($urandom);
            cycle(($urandom % 16) != 0, rq, ($urandom % 6) == 0, ($urandom % 200) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
